output_accum_sequencer: RTL and testbench

OUTPUT_ACCUM_SEQUENCER -- requirements
Module: output_accum_sequencer

---
 rtl/output_accum_sequencer_if.sv | 35 +++
 rtl/output_accum_sequencer.sv | 135 +++++++++++++
 tb/tb_output_accum_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_accum_sequencer_if.sv
// Output-accumulation sequencer bus: tile command, systolic-output handshake, BRAM lane controls.
// Ports: en/mode/lane_mask/base_addr/tile_len/in_valid toward the sequencer, the rest from it.
// master = tile controller / systolic array side, slave = sequencer side.
interface output_accum_sequencer_if #(
  parameter int NUM_LANES = 16,
  parameter int AW        = 10
);
  logic                 en;
  logic                 mode;
  logic [NUM_LANES-1:0] lane_mask;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          tile_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        addr;
  logic [NUM_LANES-1:0] enb_result;
  logic [NUM_LANES-1:0] ena_result;
  logic [NUM_LANES-1:0] wea_result;
  logic                 sel_acc;
  logic                 en_reg_adder;
  logic                 done;
  logic                 busy;

  modport master (
    output en, mode, lane_mask, base_addr, tile_len, in_valid,
    input  in_ready, addr, enb_result, ena_result, wea_result,
    input  sel_acc, en_reg_adder, done, busy
  );

  modport slave (
    input  en, mode, lane_mask, base_addr, tile_len, in_valid,
    output in_ready, addr, enb_result, ena_result, wea_result,
    output sel_acc, en_reg_adder, done, busy
  );
endinterface

// File: rtl/output_accum_sequencer.sv
// Sequences read-modify-write (or plain write) of one systolic output tile into per-lane result BRAMs.
// Latency: 5+RD_LAT cycles per element in accumulate mode, 3 in overwrite mode; done one cycle after the last element.
// Backpressure: in_ready is high only while waiting for a value; in_valid is ignored at all other times.
// Ports: clk, rst (async active-low), bus (slave modport): tile command in, handshake, BRAM enables,
//        shared address, adder operand select / register enable, done pulse, busy level.
module output_accum_sequencer #(
  parameter int DW        = 16,
  parameter int NUM_LANES = 16,
  parameter int RD_LAT    = 1,
  parameter int AW        = 10
) (
  input logic                     clk,
  input logic                     rst,
  output_accum_sequencer_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..4");
  end
  if (DW < 1) begin : g_bad_dw
    $error("DW must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VAL, S_READ, S_WAIT_LAT, S_LATCH, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

  state_t               state, state_n;
  logic [AW:0]          idx, idx_n;       // one bit wider than the address so a full 2^AW tile fits
  logic [AW:0]          len_l, len_n;
  logic                 mode_l, mode_n;
  logic [NUM_LANES-1:0] mask_l, mask_n;
  logic [AW-1:0]        base_l, base_n;
  logic [2:0]           lat_cnt, lat_n;

  logic                 in_ready_q, sel_q, adder_q, done_q, busy_q;
  logic [AW-1:0]        addr_q;
  logic [NUM_LANES-1:0] enb_q, wr_q;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_l;
    mode_n  = mode_l;
    mask_n  = mask_l;
    base_n  = base_l;
    lat_n   = lat_cnt;
    case (state)
      S_IDLE: begin
        if (bus.en) begin
          mode_n  = bus.mode;
          mask_n  = bus.lane_mask;
          base_n  = bus.base_addr;
          len_n   = bus.tile_len;
          idx_n   = '0;
          state_n = (bus.tile_len == '0) ? S_DONE : S_WAIT_VAL;
        end
      end
      S_WAIT_VAL: begin
        if (bus.in_valid) state_n = mode_l ? S_WRITE : S_READ;
      end
      S_READ: begin
        lat_n   = '0;
        state_n = S_WAIT_LAT;
      end
      S_WAIT_LAT: begin
        if (lat_cnt == LAT_LAST) state_n = S_LATCH;
        else                     lat_n   = lat_cnt + 3'd1;
      end
      S_LATCH:   state_n = S_WRITE;
      S_WRITE:   state_n = S_ADVANCE;
      S_ADVANCE: begin
        if (idx == len_l - IDX_ONE) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + IDX_ONE;
          state_n = S_WAIT_VAL;
        end
      end
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      len_l      <= '0;
      mode_l     <= 1'b0;
      mask_l     <= '0;
      base_l     <= '0;
      lat_cnt    <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      enb_q      <= '0;
      wr_q       <= '0;
      sel_q      <= 1'b0;
      adder_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      len_l      <= len_n;
      mode_l     <= mode_n;
      mask_l     <= mask_n;
      base_l     <= base_n;
      lat_cnt    <= lat_n;
      in_ready_q <= (state_n == S_WAIT_VAL);
      addr_q     <= (state_n != S_IDLE) ? base_n + idx_n[AW-1:0] : '0;
      enb_q      <= (state_n == S_READ || state_n == S_WAIT_LAT) ? mask_n : '0;
      wr_q       <= (state_n == S_WRITE) ? mask_n : '0;
      sel_q      <= (state_n != S_IDLE) & ~mode_n;
      adder_q    <= (state_n == S_LATCH);
      done_q     <= (state_n == S_DONE);
      busy_q     <= (state_n != S_IDLE);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.addr         = addr_q;
  assign bus.enb_result   = enb_q;
  assign bus.ena_result   = wr_q;
  assign bus.wea_result   = wr_q;
  assign bus.sel_acc      = sel_q;
  assign bus.en_reg_adder = adder_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_output_accum_sequencer.sv
// Bench for output_accum_sequencer: two instances (RD_LAT=1 and RD_LAT=3) on shared stimulus,
// each checked every cycle against a beat-queue model of the element schedule,
// plus literal expectations for the directed tiles.
module tb_output_accum_sequencer;
  localparam int NL = 16;
  localparam int AW = 10;
  localparam int LW = AW + 1;

  typedef struct packed {
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [NL-1:0] enb;
    logic [NL-1:0] ena;
    logic [NL-1:0] wea;
    logic          sel_acc;
    logic          en_reg_adder;
    logic          done;
    logic          busy;
  } beat_t;

  localparam int K_WAIT = 0, K_ENB = 1, K_LATCH = 2, K_WRITE = 3, K_PLAIN = 4, K_DONE = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [NL-1:0] lane_mask = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   tile_len = '0;

  output_accum_sequencer_if #(.NUM_LANES(NL), .AW(AW)) bus0 ();
  output_accum_sequencer_if #(.NUM_LANES(NL), .AW(AW)) bus1 ();

  assign bus0.en = en;  assign bus0.mode = mode;  assign bus0.lane_mask = lane_mask;
  assign bus0.base_addr = base_addr;  assign bus0.tile_len = tile_len;  assign bus0.in_valid = in_valid;
  assign bus1.en = en;  assign bus1.mode = mode;  assign bus1.lane_mask = lane_mask;
  assign bus1.base_addr = base_addr;  assign bus1.tile_len = tile_len;  assign bus1.in_valid = in_valid;

  output_accum_sequencer #(.DW(16), .NUM_LANES(NL), .RD_LAT(1), .AW(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  output_accum_sequencer #(.DW(16), .NUM_LANES(NL), .RD_LAT(3), .AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  beat_t dut_b [2];
  assign dut_b[0] = {bus0.in_ready, bus0.addr, bus0.enb_result, bus0.ena_result, bus0.wea_result,
                     bus0.sel_acc, bus0.en_reg_adder, bus0.done, bus0.busy};
  assign dut_b[1] = {bus1.in_ready, bus1.addr, bus1.enb_result, bus1.ena_result, bus1.wea_result,
                     bus1.sel_acc, bus1.en_reg_adder, bus1.done, bus1.busy};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for a value, 2 playing out a scheduled beat sequence
  int            phase [2];
  beat_t         q [2][$];
  beat_t         exp_b [2];
  logic          m_mode [2];
  logic [NL-1:0] m_mask [2];
  logic [AW-1:0] m_base [2];
  int            m_len [2];
  int            m_idx [2];
  bit            m_fin [2];

  function automatic int rdl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic beat_t mk(input int d, input int k);
    beat_t b;
    b = '0;
    b.busy    = 1'b1;
    b.sel_acc = ~m_mode[d];
    b.addr    = m_base[d] + AW'(m_idx[d]);
    case (k)
      K_WAIT:  b.in_ready = 1'b1;
      K_ENB:   b.enb = m_mask[d];
      K_LATCH: b.en_reg_adder = 1'b1;
      K_WRITE: begin b.ena = m_mask[d]; b.wea = m_mask[d]; end
      K_DONE:  b.done = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

  task automatic model_step(input int d);
    case (phase[d])
      0: begin
        if (en) begin
          m_mode[d] = mode;  m_mask[d] = lane_mask;  m_base[d] = base_addr;
          m_len[d] = int'(tile_len);  m_idx[d] = 0;
          if (m_len[d] == 0) begin
            m_fin[d] = 1'b1;
            q[d].push_back(mk(d, K_DONE));
            phase[d] = 2;
            exp_b[d] = q[d].pop_front();
          end else begin
            m_fin[d] = 1'b0;
            phase[d] = 1;
            exp_b[d] = mk(d, K_WAIT);
          end
        end else begin
          exp_b[d] = '0;
        end
      end
      1: begin
        if (in_valid) begin
          m_fin[d] = (m_idx[d] == m_len[d] - 1);
          if (!m_mode[d]) begin
            for (int i = 0; i < 1 + rdl(d); i++) q[d].push_back(mk(d, K_ENB));
            q[d].push_back(mk(d, K_LATCH));
          end
          q[d].push_back(mk(d, K_WRITE));
          q[d].push_back(mk(d, K_PLAIN));
          if (m_fin[d]) q[d].push_back(mk(d, K_DONE));
          phase[d] = 2;
          exp_b[d] = q[d].pop_front();
        end else begin
          exp_b[d] = mk(d, K_WAIT);
        end
      end
      default: begin
        if (q[d].size() > 0) begin
          exp_b[d] = q[d].pop_front();
        end else if (m_fin[d]) begin
          phase[d] = 0;
          exp_b[d] = '0;
        end else begin
          m_idx[d]++;
          phase[d] = 1;
          exp_b[d] = mk(d, K_WAIT);
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = 0;  q[d].delete();  exp_b[d] = '0;
        m_mode[d] = 1'b0;  m_mask[d] = '0;  m_base[d] = '0;
        m_len[d] = 0;  m_idx[d] = 0;  m_fin[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // ---------------- compare + per-tile statistics ----------------
  int            tile_cyc = 0;
  int            n_enb [2], first_enb [2], n_lat [2], lat_cyc [2], n_wr [2], wr_cyc [2];
  int            n_done [2], done_cyc [2], n_sel [2], n_rdy [2], any_en [2];
  logic [NL-1:0] last_wea [2];
  logic [AW-1:0] wr_addr [2][$];

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      n_enb[d] = 0;  first_enb[d] = 0;  n_lat[d] = 0;  lat_cyc[d] = 0;  n_wr[d] = 0;  wr_cyc[d] = 0;
      n_done[d] = 0;  done_cyc[d] = 0;  n_sel[d] = 0;  n_rdy[d] = 0;  any_en[d] = 0;
      last_wea[d] = '0;  wr_addr[d].delete();
    end
  endtask

  initial begin
    beat_t b;
    forever begin
      @(posedge clk);
      #1;
      tile_cyc++;
      for (int d = 0; d < 2; d++) begin
        b = dut_b[d];
        check($sformatf("cycle_dut%0d_t%0t", d, $time), 64'(b), 64'(exp_b[d]));
        if (b.enb != '0) begin
          if (n_enb[d] == 0) first_enb[d] = tile_cyc;
          n_enb[d]++;
        end
        if (b.en_reg_adder) begin n_lat[d]++; lat_cyc[d] = tile_cyc; end
        if (b.wea != '0) begin
          n_wr[d]++;  wr_cyc[d] = tile_cyc;  last_wea[d] = b.wea;  wr_addr[d].push_back(b.addr);
        end
        if ((b.enb | b.ena | b.wea) != '0) any_en[d]++;
        if (b.done) begin n_done[d]++; done_cyc[d] = tile_cyc; end
        if (b.sel_acc) n_sel[d]++;
        if (b.in_ready) n_rdy[d]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic vld(input int p, input int n);
    case (p)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (n % 6 == 5);
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus0.busy || bus1.busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 64'(bus0.busy | bus1.busy), 64'd0);
  endtask

  task automatic launch(input logic md, input logic [NL-1:0] msk, input logic [AW-1:0] b,
                        input logic [AW:0] len, input int policy);
    wait_idle();
    @(negedge clk);
    mode = md;  lane_mask = msk;  base_addr = b;  tile_len = len;  en = 1'b1;
    in_valid = vld(policy, 0);
    clear_stats();
    tile_cyc = 1;
  endtask

  task automatic run_tile(input logic md, input logic [NL-1:0] msk, input logic [AW-1:0] b,
                          input logic [AW:0] len, input int policy, input bit noise);
    int n;
    bit ok;
    launch(md, msk, b, len, policy);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20000) begin
      @(negedge clk);
      n++;
      // latched fields must not matter after the start cycle
      mode = 1'($urandom);  lane_mask = NL'($urandom);  base_addr = AW'($urandom);  tile_len = LW'($urandom);
      en = noise && bus0.busy && bus1.busy && ($urandom_range(0, 3) == 0);
      in_valid = vld(policy, n);
      ok = (n_done[0] > 0) && (n_done[1] > 0) && !bus0.busy && !bus1.busy;
    end
    en = 1'b0;
    check("tile_complete", 64'(ok), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_dut0", 64'(dut_b[0]), 64'd0);
    check("reset_dut1", 64'(dut_b[1]), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'(dut_b[0]), 64'd0);

    // accumulate, RD_LAT=1 instance: 3 elements, value always present
    run_tile(1'b0, 16'hFFFF, 10'h010, 11'd3, 0, 1'b0);
    check("acc_wr_addr0", 64'(wr_addr[0][0]), 64'h010);
    check("acc_wr_addr1", 64'(wr_addr[0][1]), 64'h011);
    check("acc_wr_addr2", 64'(wr_addr[0][2]), 64'h012);
    check("acc_enb_cycles", 64'(n_enb[0]), 64'd6);
    check("acc_adder_pulses", 64'(n_lat[0]), 64'd3);
    check("acc_writes", 64'(n_wr[0]), 64'd3);
    check("acc_done_cycle", 64'(done_cyc[0]), 64'd20);
    check("acc_done_count", 64'(n_done[0]), 64'd1);
    check("acc_sel_cycles", 64'(n_sel[0]), 64'd19);

    // overwrite, partial mask
    run_tile(1'b1, 16'h00F0, 10'h100, 11'd4, 0, 1'b0);
    check("ovw_enb", 64'(n_enb[0]), 64'd0);
    check("ovw_adder", 64'(n_lat[0]), 64'd0);
    check("ovw_writes", 64'(n_wr[0]), 64'd4);
    check("ovw_wea", 64'(last_wea[0]), 64'h00F0);
    check("ovw_sel", 64'(n_sel[0]), 64'd0);
    check("ovw_done_count", 64'(n_done[0]), 64'd1);

    // RD_LAT=3 instance, single element
    run_tile(1'b0, 16'hFFFF, 10'h000, 11'd1, 0, 1'b0);
    check("lat3_first_enb", 64'(first_enb[1]), 64'd3);
    check("lat3_enb_cycles", 64'(n_enb[1]), 64'd4);
    check("lat3_adder_cycle", 64'(lat_cyc[1]), 64'd7);
    check("lat3_write_cycle", 64'(wr_cyc[1]), 64'd8);
    check("lat3_done_cycle", 64'(done_cyc[1]), 64'd10);

    // empty tile
    run_tile(1'b0, 16'hFFFF, 10'h055, 11'd0, 0, 1'b0);
    check("len0_done_cycle", 64'(done_cyc[0]), 64'd2);
    check("len0_no_enables", 64'(any_en[0] + any_en[1]), 64'd0);

    // address wrap
    run_tile(1'b0, 16'h0001, 10'h3FF, 11'd2, 0, 1'b0);
    check("wrap_addr0", 64'(wr_addr[0][0]), 64'h3FF);
    check("wrap_addr1", 64'(wr_addr[0][1]), 64'h000);

    // lane_mask = 0 still sequences
    run_tile(1'b0, 16'h0000, 10'h005, 11'd2, 0, 1'b0);
    check("mask0_no_enables", 64'(any_en[0] + any_en[1]), 64'd0);
    check("mask0_adder", 64'(n_lat[0]), 64'd2);
    check("mask0_done", 64'(n_done[0]), 64'd1);

    // 5-cycle in_valid gaps with stray en pulses
    run_tile(1'b1, 16'h8001, 10'h200, 11'd2, 2, 1'b1);
    check("gap_ready_cycles", 64'(n_rdy[0]), 64'd9);
    check("gap_done_cycle", 64'(done_cyc[0]), 64'd15);
    check("gap_writes", 64'(n_wr[0]), 64'd2);

    // reset while both instances sit in WAIT_LAT
    launch(1'b0, 16'hFFFF, 10'h040, 11'd3, 0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_enb_dut0", 64'(dut_b[0].enb), 64'hFFFF);
    check("pre_rst_enb_dut1", 64'(dut_b[1].enb), 64'hFFFF);
    #1 rst = 1'b0;
    #1;
    check("rst_async_dut0", 64'(dut_b[0]), 64'd0);
    check("rst_async_dut1", 64'(dut_b[1]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    run_tile(1'b1, 16'h000F, 10'h020, 11'd2, 0, 1'b0);
    check("restart_addr0", 64'(wr_addr[0][0]), 64'h020);
    check("restart_addr1", 64'(wr_addr[0][1]), 64'h021);
    check("restart_done_cycle", 64'(done_cyc[0]), 64'd8);

    // full 2^AW tile
    run_tile(1'b1, 16'h0001, 10'h200, 11'h400, 0, 1'b0);
    check("full_writes", 64'(n_wr[0]), 64'd1024);
    check("full_last_addr", 64'(wr_addr[0][1023]), 64'h1FF);
    check("full_done_cycle", 64'(done_cyc[0]), 64'd3074);

    // randomized tiles
    for (int t = 0; t < 16; t++) begin
      run_tile(1'($urandom), ($urandom_range(0, 4) == 0) ? 16'h0000 : NL'($urandom),
               AW'($urandom), LW'($urandom_range(0, 5)), $urandom_range(1, 3), 1'($urandom));
      check($sformatf("rand%0d_done_count", t), 64'(n_done[0]), 64'd1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
